// File: rtl/hsv_colour_bbox.sv
// HSV colour-window classifier with per-frame bounding box, match count and mask.
// HSV_COLOUR_BBOX_RUN_FILTER_EN: count a pixel only if the previous pixel in its row also matched.
module hsv_colour_bbox #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int XW      = 11,
  parameter int YW      = 10,
  parameter int CNT_W   = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [8:0]       hsv_h,
  input  logic [7:0]       hsv_s,
  input  logic [7:0]       hsv_v,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [8:0]       h_min,
  input  logic [8:0]       h_max,
  input  logic [7:0]       s_min,
  input  logic [7:0]       v_min,
  output logic             mask_out,
  output logic             mask_valid,
  output logic             bbox_valid,
  output logic             bbox_found,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [YW-1:0]    y_min,
  output logic [YW-1:0]    y_max,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_H - 1);

  state_t state_q, state_d;

  logic [XW-1:0]    x_q, cx, nx;
  logic [YW-1:0]    y_q, cy, ny;
  logic             accept, hue_ok, match, counted;

  logic             found_q, found_b, found_d;
  logic [XW-1:0]    xmin_q, xmin_b, xmin_d;
  logic [XW-1:0]    xmax_q, xmax_b, xmax_d;
  logic [YW-1:0]    ymin_q, ymin_b, ymin_d;
  logic [YW-1:0]    ymax_q, ymax_b, ymax_d;
  logic [CNT_W-1:0] cnt_q, cnt_b, cnt_d;

  assign accept = in_valid && (state_q == ACTIVE || in_sop);
  assign cx     = in_sop ? '0 : x_q;
  assign cy     = in_sop ? '0 : y_q;

  assign hue_ok = (h_min <= h_max)
                ? (hsv_h >= h_min && hsv_h <= h_max)
                : (hsv_h >= h_min || hsv_h <= h_max);
  assign match  = hue_ok && hsv_s >= s_min && hsv_v >= v_min;

`ifdef HSV_COLOUR_BBOX_RUN_FILTER_EN
  logic prev_q;
  assign counted = match && prev_q && (cx != '0);

  always_ff @(posedge clk) begin
    if (rst)         prev_q <= 1'b0;
    else if (accept) prev_q <= match;
  end
`else
  assign counted = match;
`endif

  // A sop pixel starts from empty accumulators, discarding any partial frame
  assign found_b = in_sop ? 1'b0 : found_q;
  assign xmin_b  = in_sop ? '0 : xmin_q;
  assign xmax_b  = in_sop ? '0 : xmax_q;
  assign ymin_b  = in_sop ? '0 : ymin_q;
  assign ymax_b  = in_sop ? '0 : ymax_q;
  assign cnt_b   = in_sop ? '0 : cnt_q;

  always_comb begin
    found_d = found_b;
    xmin_d  = xmin_b;
    xmax_d  = xmax_b;
    ymin_d  = ymin_b;
    ymax_d  = ymax_b;
    cnt_d   = cnt_b;
    if (counted) begin
      found_d = 1'b1;
      xmin_d  = (!found_b || cx < xmin_b) ? cx : xmin_b;
      xmax_d  = (!found_b || cx > xmax_b) ? cx : xmax_b;
      ymin_d  = (!found_b || cy < ymin_b) ? cy : ymin_b;
      ymax_d  = (!found_b || cy > ymax_b) ? cy : ymax_b;
      cnt_d   = (&cnt_b) ? cnt_b : cnt_b + 1'b1;
    end
  end

  always_comb begin
    nx = cx + 1'b1;
    ny = cy;
    if (cx == X_LAST) begin
      nx = '0;
      ny = (cy == Y_LAST) ? cy : cy + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_eop)      state_d = IDLE;
      else if (in_sop) state_d = ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      found_q    <= 1'b0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymin_q     <= '0;
      ymax_q     <= '0;
      cnt_q      <= '0;
      mask_out   <= 1'b0;
      mask_valid <= 1'b0;
      bbox_valid <= 1'b0;
      bbox_found <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      match_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      mask_valid <= accept;
      mask_out   <= accept && match;
      bbox_valid <= accept && in_eop;
      if (accept) begin
        x_q     <= nx;
        y_q     <= ny;
        found_q <= found_d;
        xmin_q  <= xmin_d;
        xmax_q  <= xmax_d;
        ymin_q  <= ymin_d;
        ymax_q  <= ymax_d;
        cnt_q   <= cnt_d;
        if (in_eop) begin
          bbox_found <= found_d;
          x_min      <= found_d ? xmin_d : '0;
          x_max      <= found_d ? xmax_d : '0;
          y_min      <= found_d ? ymin_d : '0;
          y_max      <= found_d ? ymax_d : '0;
          match_cnt  <= found_d ? cnt_d : '0;
        end
      end
    end
  end

endmodule

// File: doc/hsv_colour_bbox.md
Name: hsv_colour_bbox

Overview:
Streaming consumer of the RGB_2_HSV stage. Classifies each HSV pixel against a programmable colour window and accumulates a per-frame bounding box and match count. Feeds target-tracking logic, e.g. ball or beacon detection. Also emits a per-pixel binary mask for video overlay.

Parameters:
IMAGE_W, 640, pixels per row
IMAGE_H, 480, rows per frame
XW, 11, x coordinate width (must hold IMAGE_W-1)
YW, 10, y coordinate width (must hold IMAGE_H-1)
CNT_W, 19, match counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hsv_h  in  9  hue 0..359
hsv_s  in  8  saturation
hsv_v  in  8  value
in_valid  in  1  pixel qualifier
in_sop  in  1  first pixel of frame; valid only with in_valid
in_eop  in  1  last pixel of frame; valid only with in_valid
h_min  in  9  hue lower bound, inclusive
h_max  in  9  hue upper bound, inclusive
s_min  in  8  saturation lower bound, inclusive
v_min  in  8  value lower bound, inclusive
mask_out  out  1  1 = current pixel matched
mask_valid  out  1  qualifies mask_out
bbox_valid  out  1  one-cycle pulse: frame result updated
bbox_found  out  1  at least one pixel counted in last frame
x_min  out  XW  leftmost counted x
x_max  out  XW  rightmost counted x
y_min  out  YW  topmost counted y
y_max  out  YW  bottommost counted y
match_cnt  out  CNT_W  counted pixels in last frame

Behaviour:
- One clock, clk; reset rst is synchronous, active-high. All outputs reset to 0. State goes to IDLE. Accumulators are cleared.
- Match: s>=s_min AND v>=v_min AND hue test.
  - If h_min<=h_max: h_min<=h<=h_max.
  - If h_min>h_max (wrapped range, e.g. red): h>=h_min OR h<=h_max.
- Threshold inputs are sampled on every accepted pixel. Changing them mid-frame is legal and takes effect from the next pixel.
- FSM states:
  - IDLE: pixels without in_sop are ignored, with no mask output. in_valid&in_sop moves to ACTIVE.
  - ACTIVE: accumulates pixels. in_valid&in_eop returns to IDLE.
- Coordinates:
  - The sop pixel is (0,0). x increments per accepted pixel.
  - At x=IMAGE_W-1, x wraps to 0 and y increments.
  - y saturates at IMAGE_H-1 if eop is late. Extra pixels still get classified.
- Accumulation per counted pixel:
  - x_min/y_min take the minimum of the running value and the current coordinate. x_max/y_max take the maximum.
  - Running accumulators start empty at sop. The sop pixel itself is included.
  - match_cnt increments and saturates at all-ones.
- Mask latency: mask_out/mask_valid are registered, 1 cycle after an accepted pixel in ACTIVE or a sop pixel. in_valid low produces mask_valid low, and the FSM holds.
- Result latency: on the eop pixel, results including that pixel are registered. bbox_valid pulses high the following cycle, for exactly one cycle.
  - Outputs hold until the next eop.
  - With no match: bbox_found=0 and all coordinates and the count read 0.
- Boundaries:
  - in_sop&in_eop on the same pixel is a 1-pixel frame: classify it, publish, return to IDLE.
  - in_sop in ACTIVE with no preceding eop: the partial frame is discarded with no bbox_valid. Restart at (0,0) with this pixel.
  - in_eop in IDLE without sop: ignored.
  - rst mid-frame: partial frame lost, published results cleared to 0, no bbox_valid pulse.

Optional Feature:
Macro HSV_COLOUR_BBOX_RUN_FILTER_EN.
- Defined: a pixel is counted into the bbox and match_cnt only if it matches AND the previous accepted pixel in the same row also matched. x=0 is never counted. mask_out still shows the raw per-pixel match.
- Undefined: every matching pixel is counted. No previous-pixel register exists.

Test Plan:
- IMAGE_W=8, IMAGE_H=4, window h 0..20, s_min=100, v_min=100. Frame all (h=0,s=254,v=255) except pixels at (2,1) and (5,2) at h=120 -> mask_out low at those two pixels only; bbox 0..7 x 0..3; match_cnt=30; bbox_valid one cycle after eop.
- Wrapped hue h_min=340, h_max=20. Pixels h=350, 10, 180, 339 at x=0..3 of row 0 -> mask 1,1,0,0; x_min=0, x_max=1, y_min=y_max=0, match_cnt=2.
- No matching pixels (all s=0) -> bbox_found=0; x_min/x_max/y_min/y_max/match_cnt all 0; bbox_valid still pulses.
- Mid-frame sop after 10 pixels, then a full frame with a single match at (3,2) -> one bbox_valid only; x_min=x_max=3, y_min=y_max=2, cnt=1.
- Single pixel with sop&eop, matching -> bbox_found=1, count 1, coordinates 0, bbox_valid next cycle. rst asserted mid-frame -> all outputs 0; pixels ignored until next sop.
- RUN_FILTER_EN: row 0 mask pattern 0,1,1,0,1,0,0,0 -> counted only x=2; match_cnt=1, x_min=x_max=2.
